branch_cmp_serial: RTL
======================

# branch_cmp_serial

Parametrised, multi-cycle branch comparator for the execute stage. It evaluates the RV64 branch conditions (EQ/NE/LT/GE/LTU/GEU, plus the "never" and "always" jump codes) by scanning the operands in SLICE-bit slices, most-significant first. It exits early on the first differing slice. Operands enter and the result leaves through valid/ready handshakes, and a flush input cancels an in-flight compare on mispredict or trap.

## Interface
- XLEN, default 64: operand width.
- SLICE, default 16: bits examined per cycle. XLEN % SLICE == 0 is required. NSLICE = XLEN/SLICE; SLICE == XLEN gives single-slice operation.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous and active-low.
- flush  input  1  cancel any in-flight compare.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- a, b  input  XLEN  operands.
- cmp_op  input  3  opcode:
  - 0 NO, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 ALWAYS.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res  output  1  branch/jump taken.
- busy  output  1  state != IDLE.

## Operation
- States:
  - IDLE: in_ready = !flush.
  - BUSY: scanning slices.
  - DONE: out_valid = 1.
- Accept in IDLE (in_valid && in_ready):
  - Latch a, b, cmp_op; set slice index idx = NSLICE-1.
  - op 0: next state DONE with res=0; op 7: next state DONE with res=1.
  - Any other op: next state BUSY.
- BUSY, each cycle, compare slice idx of a vs b:
  - If idx == NSLICE-1 and the op is LT or GE, compare that slice as signed; otherwise compare unsigned.
  - Slices differ: eq=0, lt = (a_slice < b_slice); go to DONE.
  - Slices equal and idx == 0: eq=1, lt=0; go to DONE.
  - Otherwise: idx decrements; stay in BUSY.
- Result in DONE:
  - EQ = eq; NE = !eq.
  - LT / LTU = lt.
  - GE / GEU = !lt.
- DONE: res and out_valid are held stable until out_ready. On the out_valid && out_ready cycle, go to IDLE. No new request is accepted in that same cycle (in_ready is low in DONE).
- Unknown op encodings cannot occur (3-bit field is fully decoded).
- flush = 1 in any state: next state IDLE, out_valid low next cycle, latched result discarded.
  - Flush has priority over accept and over the out_ready handshake.
  - A result sitting in DONE while flush is high is not considered delivered, even if out_ready is high.
- rstn = 0 at a rising edge:
  - state = IDLE, idx = 0, res = 0, out_valid = 0, busy = 0.
  - in_ready reads 0 while rstn is low.
  - Reset mid-operation behaves exactly like flush.

## Timing
- Accept at edge T0.
- NO/ALWAYS: out_valid high in cycle T0+1.
- Other ops: k = number of slices examined (1..NSLICE); out_valid is first high in cycle T0+k+1.
  - Worst case NSLICE+1 = 5 cycles at the defaults.
  - Best case 2 cycles (top slice differs).
- Throughput:
  - One request per k+2 cycles with out_ready held high.
  - No overlap between requests: the block is unpipelined by design.
- Outputs:
  - res, out_valid and busy are registered.
  - in_ready is the only combinational output, derived from state, flush and rstn.
- a, b and cmp_op are sampled only on the accept edge; later changes have no effect.

## Test plan
- EQ equal operands: a = b = 0x1234_5678_9ABC_DEF0, op 1 → res=1, out_valid at T0+5; op 2 with the same operands → res=0.
- Signed vs unsigned, top slice differs:
  - a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, op 3 → res=1 at T0+2.
  - Same operands, op 5 → res=0 at T0+2.
  - Same operands, op 4 → res=0.
- Bottom slice differs: a = 5, b = 3, op 6 → res=1 at T0+5; op 3 → res=0 at T0+5.
- Trivial ops: op 7 with any operands → res=1 at T0+1; op 0 → res=0 at T0+1; busy high for exactly 1 cycle when out_ready=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE → res and out_valid stay constant, in_ready=0, and a new in_valid is not accepted.
  - Raise out_ready → IDLE next cycle; the following request is accepted.
- Flush/reset mid-scan:
  - Assert flush in BUSY at idx=2 → out_valid never rises for that request; IDLE next cycle.
  - flush together with in_valid in IDLE → no accept.
  - Repeat with rstn=0 in BUSY → all outputs 0 next cycle; a fresh compare afterwards gives the correct result.

Source files
------------

// File: rtl/branch_cmp_serial.sv
// Multi-cycle RV64 branch comparator: scans operands MSB-slice first, exits on the first
// differing slice, with valid/ready handshakes on both sides and a flush cancel.
module branch_cmp_serial #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      cmp_op_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            res_o,
    output logic            busy_o
);
    localparam int unsigned NSlice = XLEN / SLICE;
    localparam int unsigned IdxW   = (NSlice > 1) ? $clog2(NSlice) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NSlice - 1);

    localparam logic [2:0] OpNo     = 3'd0;
    localparam logic [2:0] OpEq     = 3'd1;
    localparam logic [2:0] OpNe     = 3'd2;
    localparam logic [2:0] OpLt     = 3'd3;
    localparam logic [2:0] OpGe     = 3'd4;
    localparam logic [2:0] OpLtu    = 3'd5;
    localparam logic [2:0] OpGeu    = 3'd6;
    localparam logic [2:0] OpAlways = 3'd7;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        op_q;
    logic              res_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic              sgn_cmp;
    logic              slice_lt;
    logic              slice_ne;

    function automatic logic resolve(input logic [2:0] op, input logic eq, input logic lt);
        logic r;
        r = 1'b0;
        case (op)
            OpEq:          r = eq;
            OpNe:          r = !eq;
            OpLt, OpLtu:   r = lt;
            OpGe, OpGeu:   r = !lt;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NSlice; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
        // Only the sign-carrying top slice of LT/GE is compared as signed.
        sgn_cmp  = (idx_q == IdxTop) && (op_q == OpLt || op_q == OpGe);
        slice_lt = sgn_cmp ? ($signed(a_sl) < $signed(b_sl)) : (a_sl < b_sl);
        slice_ne = (a_sl != b_sl);
    end

    assign in_ready_o  = rstn_i && !flush_i && (state_q == StIdle);
    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign busy_o      = busy_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            res_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush_i) begin
            state_q     <= StIdle;
            res_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        op_q   <= cmp_op_i;
                        idx_q  <= IdxTop;
                        busy_q <= 1'b1;
                        if (cmp_op_i == OpNo || cmp_op_i == OpAlways) begin
                            state_q     <= StDone;
                            res_q       <= (cmp_op_i == OpAlways);
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (slice_ne) begin
                        state_q     <= StDone;
                        res_q       <= resolve(op_q, 1'b0, slice_lt);
                        out_valid_q <= 1'b1;
                    end else if (idx_q == '0) begin
                        state_q     <= StDone;
                        res_q       <= resolve(op_q, 1'b1, 1'b0);
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
